// File: rtl/mandel_dispatch_sched.sv
// Frame scheduler: latches the view per frame, deals pixel jobs round-robin to the
// iteration engines and re-serialises their depths into a raster-order pixel stream.
module mandel_dispatch_sched #(
    parameter int NUM_ENGINES  = 4,
    parameter int X_SIZE       = 960,
    parameter int Y_SIZE       = 720,
    parameter int MAX_INFLIGHT = 8,
    parameter int DEPTH_W      = 10
) (
    input  logic                           out_stream_aclk,
    input  logic                           periph_resetn,
    input  logic                           enable,
    input  logic [31:0]                    cfg_max_iter,
    input  logic [31:0]                    cfg_zoom,
    input  logic [31:0]                    cfg_real_center,
    input  logic [31:0]                    cfg_imag_center,
    output logic [NUM_ENGINES-1:0]         job_valid,
    input  logic [NUM_ENGINES-1:0]         job_ready,
    output logic [10:0]                    job_x,
    output logic [10:0]                    job_y,
    output logic [31:0]                    job_max_iter,
    output logic [31:0]                    job_zoom,
    output logic [31:0]                    job_real_center,
    output logic [31:0]                    job_imag_center,
    input  logic [NUM_ENGINES-1:0]         res_valid,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] res_depth,
    output logic [NUM_ENGINES-1:0]         res_ready,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [DEPTH_W-1:0]             pix_depth,
    output logic                           pix_sof,
    output logic                           pix_eol,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int EW    = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int IW    = $clog2(MAX_INFLIGHT + 1);
    localparam int TOTAL = X_SIZE * Y_SIZE;
    localparam int PW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, LATCH, RUN, DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [EW-1:0]      d_reg, c_reg;
    logic [10:0]        x_reg, y_reg, ox_reg, oy_reg;
    logic [IW-1:0]      inflight_reg;
    logic [PW-1:0]      out_left_reg;
    logic               pix_last_reg;
    logic               dispatch_ok, collect_ok;
    logic               job_fire, res_fire, last_job, last_out;
    logic [DEPTH_W-1:0] sel_depth;

    assign dispatch_ok = (state_reg == RUN) && (inflight_reg < IW'(MAX_INFLIGHT));
    assign collect_ok  = (!pix_valid || pix_ready) && (out_left_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_eng
            assign job_valid[gi] = dispatch_ok && (d_reg == EW'(gi));
            assign res_ready[gi] = collect_ok && (c_reg == EW'(gi));
        end
    endgenerate

    assign job_fire  = |(job_valid & job_ready);
    assign res_fire  = |(res_valid & res_ready);
    assign last_job  = job_fire && (x_reg == 11'(X_SIZE - 1)) && (y_reg == 11'(Y_SIZE - 1));
    assign last_out  = pix_valid && pix_ready && pix_last_reg;
    assign sel_depth = res_depth[c_reg * DEPTH_W +: DEPTH_W];
    assign job_x     = x_reg;
    assign job_y     = y_reg;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = LATCH;
            LATCH:   state_next = RUN;
            RUN:     if (last_job) state_next = DRAIN;
            DRAIN:   if (last_out) state_next = enable ? LATCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_reg       <= IDLE;
            frame_done      <= 1'b0;
            job_max_iter    <= '0;
            job_zoom        <= '0;
            job_real_center <= '0;
            job_imag_center <= '0;
            d_reg           <= '0;
            c_reg           <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            ox_reg          <= '0;
            oy_reg          <= '0;
            out_left_reg    <= '0;
            inflight_reg    <= '0;
            pix_valid       <= 1'b0;
            pix_depth       <= '0;
            pix_sof         <= 1'b0;
            pix_eol         <= 1'b0;
            pix_last_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            frame_done <= (state_reg == DRAIN) && last_out;

            // Shadow registers move only here, so mid-frame cfg writes never tear a frame.
            if (state_reg == LATCH) begin
                job_max_iter    <= cfg_max_iter;
                job_zoom        <= cfg_zoom;
                job_real_center <= cfg_real_center;
                job_imag_center <= cfg_imag_center;
                d_reg           <= '0;
                x_reg           <= '0;
                y_reg           <= '0;
            end else if (job_fire) begin
                d_reg <= (d_reg == EW'(NUM_ENGINES - 1)) ? '0 : d_reg + 1'b1;
                if (x_reg == 11'(X_SIZE - 1)) begin
                    x_reg <= '0;
                    y_reg <= (y_reg == 11'(Y_SIZE - 1)) ? '0 : y_reg + 11'd1;
                end else begin
                    x_reg <= x_reg + 11'd1;
                end
            end

            if (job_fire && !res_fire)
                inflight_reg <= inflight_reg + 1'b1;
            else if (!job_fire && res_fire)
                inflight_reg <= inflight_reg - 1'b1;

            if (state_reg == LATCH) begin
                c_reg        <= '0;
                ox_reg       <= '0;
                oy_reg       <= '0;
                out_left_reg <= PW'(TOTAL);
            end else if (res_fire) begin
                c_reg        <= (c_reg == EW'(NUM_ENGINES - 1)) ? '0 : c_reg + 1'b1;
                out_left_reg <= out_left_reg - 1'b1;
                if (ox_reg == 11'(X_SIZE - 1)) begin
                    ox_reg <= '0;
                    oy_reg <= (oy_reg == 11'(Y_SIZE - 1)) ? '0 : oy_reg + 11'd1;
                end else begin
                    ox_reg <= ox_reg + 11'd1;
                end
            end

            if (res_fire) begin
                pix_valid    <= 1'b1;
                pix_depth    <= sel_depth;
                pix_sof      <= (ox_reg == '0) && (oy_reg == '0);
                pix_eol      <= (ox_reg == 11'(X_SIZE - 1));
                pix_last_reg <= (ox_reg == 11'(X_SIZE - 1)) && (oy_reg == 11'(Y_SIZE - 1));
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mandel_dispatch_sched.sv
// Scoreboard bench: 4x4 frame over two behavioural engines; stimulus queues expected
// pixels, a negedge monitor checks every job and pixel handshake against them.
module tb_mandel_dispatch_sched;

    localparam int NE = 2, XS = 4, YS = 4, MI = 8, DW = 10, NPIX = XS * YS;

    logic               clk = 1'b0;
    logic               periph_resetn = 1'b0;
    logic               enable = 1'b0;
    logic [31:0]        cfg_max_iter = 32'd200;
    logic [31:0]        cfg_zoom = 32'd1;
    logic [31:0]        cfg_real_center = 32'h0000_1234;
    logic [31:0]        cfg_imag_center = 32'h0000_abcd;
    logic [NE-1:0]      job_valid;
    logic [NE-1:0]      job_ready = '1;
    logic [10:0]        job_x, job_y;
    logic [31:0]        job_max_iter, job_zoom, job_real_center, job_imag_center;
    logic [NE-1:0]      res_valid = '0;
    logic [NE*DW-1:0]   res_depth = '0;
    logic [NE-1:0]      res_ready;
    logic               pix_valid;
    logic               pix_ready = 1'b1;
    logic [DW-1:0]      pix_depth;
    logic               pix_sof, pix_eol, busy, frame_done;

    mandel_dispatch_sched #(
        .NUM_ENGINES(NE), .X_SIZE(XS), .Y_SIZE(YS), .MAX_INFLIGHT(MI), .DEPTH_W(DW)
    ) dut (
        .out_stream_aclk(clk), .periph_resetn(periph_resetn), .enable(enable),
        .cfg_max_iter(cfg_max_iter), .cfg_zoom(cfg_zoom),
        .cfg_real_center(cfg_real_center), .cfg_imag_center(cfg_imag_center),
        .job_valid(job_valid), .job_ready(job_ready), .job_x(job_x), .job_y(job_y),
        .job_max_iter(job_max_iter), .job_zoom(job_zoom),
        .job_real_center(job_real_center), .job_imag_center(job_imag_center),
        .res_valid(res_valid), .res_depth(res_depth), .res_ready(res_ready),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_depth(pix_depth),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int depth;
        bit sof;
        bit eol;
    } pix_t;

    pix_t        exp_q[$];
    int          eng_d[NE][$];
    longint      eng_t[NE][$];
    int          lat[NE];
    longint      cyc = 0;
    int          n_checks = 0, n_fail = 0;
    int          out_cnt = 0, done_cnt = 0, disp_k = 0;
    int          tb_inflight = 0, peak = 0;
    logic [31:0] exp_zoom = 32'd1;
    logic        prev_stall = 1'b0;
    logic [DW-1:0] prev_depth;
    logic        prev_sof, prev_eol;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        pix_t p;
        for (int k = 0; k < NPIX; k++) begin
            p.depth = k;
            p.sof   = (k == 0);
            p.eol   = ((k % XS) == XS - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic wait_done(input int budget);
        int got = 0;
        for (int i = 0; i < budget && got == 0; i++) begin
            @(negedge clk);
            if (frame_done) got = 1;
        end
        chk("frame_done_seen", got, 1);
    endtask

    // Behavioural engines: in-order per engine, fixed latency, always accepting.
    always @(posedge clk or negedge periph_resetn) begin : engines
        logic [NE-1:0] jf, rf;
        logic [10:0]   jx, jy;
        if (!periph_resetn) begin
            for (int i = 0; i < NE; i++) begin
                eng_d[i].delete();
                eng_t[i].delete();
            end
            tb_inflight = 0;
            res_valid   = '0;
            res_depth   = '0;
        end else begin
            jf = job_valid & job_ready;
            rf = res_valid & res_ready;
            jx = job_x;
            jy = job_y;
            #1;
            cyc++;
            for (int i = 0; i < NE; i++) begin
                if (rf[i] && eng_d[i].size() > 0) begin
                    void'(eng_d[i].pop_front());
                    void'(eng_t[i].pop_front());
                end
                if (jf[i]) begin
                    eng_d[i].push_back(int'(jx) + XS * int'(jy));
                    eng_t[i].push_back(cyc + lat[i]);
                end
            end
            tb_inflight = tb_inflight + $countones(jf) - $countones(rf);
            if (tb_inflight > peak) peak = tb_inflight;
            for (int i = 0; i < NE; i++) begin
                res_valid[i] = (eng_d[i].size() > 0) && (eng_t[i][0] <= cyc);
                res_depth[i*DW +: DW] = (eng_d[i].size() > 0) ? DW'(eng_d[i][0]) : '0;
            end
        end
    end

    // Monitor: pops the scoreboard on each pixel handshake and checks each job handshake.
    always @(negedge clk) begin : monitor
        pix_t e;
        logic [NE-1:0] ev;
        if (!periph_resetn) begin
            disp_k     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && pix_valid) begin
                chk("stall_depth_stable", pix_depth, prev_depth);
                chk("stall_sof_stable", pix_sof, prev_sof);
                chk("stall_eol_stable", pix_eol, prev_eol);
            end
            prev_stall = pix_valid && !pix_ready;
            prev_depth = pix_depth;
            prev_sof   = pix_sof;
            prev_eol   = pix_eol;
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pix_unexpected: got depth %0d, scoreboard empty", pix_depth);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_depth", pix_depth, e.depth);
                    chk("pix_sof", pix_sof, e.sof);
                    chk("pix_eol", pix_eol, e.eol);
                    $display("pixel %0d: depth=%0d sof=%0b eol=%0b", out_cnt, pix_depth, pix_sof, pix_eol);
                end
                out_cnt++;
            end
            if (frame_done) done_cnt++;
            if (|(job_valid & job_ready)) begin
                ev = '0;
                ev[disp_k % NE] = 1'b1;
                chk("job_engine", job_valid, ev);
                chk("job_x", job_x, disp_k % XS);
                chk("job_y", job_y, disp_k / XS);
                chk("job_zoom", job_zoom, exp_zoom);
                chk("job_max_iter", job_max_iter, 200);
                chk("job_real_center", job_real_center, 32'h1234);
                disp_k = (disp_k + 1) % NPIX;
            end
            if (tb_inflight >= MI) chk("job_valid_saturated", job_valid, 0);
        end
    end

    initial begin : stim
        int base, gaps, seen, quiet;
        lat[0] = 3;
        lat[1] = 3;

        // Reset state while held in reset
        @(negedge clk);
        chk("rst_job_valid", job_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_depth", pix_depth, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_job_zoom", job_zoom, 0);
        chk("rst_job_x", job_x, 0);
        tick(1);
        periph_resetn = 1'b1;
        tick(2);

        // Basic frame with enable dropped mid-frame
        push_frame();
        enable = 1'b1;
        tick(1);
        chk("latch_busy", busy, 1);
        chk("latch_no_job", job_valid, 0);
        tick(1);
        chk("first_job_valid", job_valid, 2'b01);
        tick(2);
        enable = 1'b0;
        wait_done(300);
        chk("basic_sb_empty", exp_q.size(), 0);
        tick(1);
        chk("idle_busy", busy, 0);
        quiet = 1;
        for (int i = 0; i < 10; i++) begin
            if (job_valid != '0) quiet = 0;
            tick(1);
        end
        chk("idle_no_jobs", quiet, 1);
        chk("done_after_basic", done_cnt, 1);

        // Out-of-order engine completion
        lat[0] = 10;
        lat[1] = 1;
        push_frame();
        enable = 1'b1;
        tick(3);
        enable = 1'b0;
        wait_done(500);
        chk("ooo_sb_empty", exp_q.size(), 0);
        tick(2);

        // Backpressure: 20 stalled cycles must saturate the in-flight window
        lat[0] = 1;
        lat[1] = 1;
        peak = 0;
        push_frame();
        base = out_cnt;
        enable = 1'b1;
        for (int i = 0; i < 100 && out_cnt < base + 2; i++) tick(1);
        chk("bp_started", out_cnt >= base + 2, 1);
        pix_ready = 1'b0;
        enable = 1'b0;
        tick(20);
        chk("bp_peak_inflight", peak, MI);
        pix_ready = 1'b1;
        gaps = 0;
        seen = 0;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
            else if (!pix_valid && exp_q.size() > 0) gaps++;
        end
        chk("bp_frame_done", seen, 1);
        chk("bp_gap_free", gaps, 0);
        chk("bp_sb_empty", exp_q.size(), 0);
        tick(2);

        // Config latch across back-to-back frames
        lat[0] = 3;
        lat[1] = 3;
        cfg_zoom = 32'd1;
        exp_zoom = 32'd1;
        push_frame();
        push_frame();
        enable = 1'b1;
        for (int i = 0; i < 200 && disp_k < 4; i++) tick(1);
        chk("cfg_reached_pixel4", disp_k >= 4, 1);
        cfg_zoom = 32'd5;
        tick(1);
        chk("cfg_zoom_held", job_zoom, 1);
        wait_done(400);
        exp_zoom = 32'd5;
        chk("b2b_busy_in_latch", busy, 1);
        @(negedge clk);
        chk("b2b_one_latch_cycle", job_valid, 2'b01);
        tick(1);
        enable = 1'b0;
        wait_done(400);
        chk("cfg_sb_empty", exp_q.size(), 0);
        chk("cfg_zoom_new_frame", job_zoom, 5);
        tick(2);

        // Asynchronous reset mid-frame
        push_frame();
        enable = 1'b1;
        for (int i = 0; i < 200 && disp_k < 6; i++) tick(1);
        chk("arst_reached_pixel6", disp_k >= 6, 1);
        @(negedge clk);
        #2;
        periph_resetn = 1'b0;
        #1;
        chk("arst_pix_valid", pix_valid, 0);
        chk("arst_job_valid", job_valid, 0);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        tick(2);
        periph_resetn = 1'b1;
        push_frame();
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (job_valid != '0) seen = 1;
        end
        chk("arst_job_seen", seen, 1);
        chk("arst_first_engine", job_valid, 2'b01);
        chk("arst_first_x", job_x, 0);
        chk("arst_first_y", job_y, 0);
        tick(1);
        enable = 1'b0;
        wait_done(400);
        chk("arst_sb_empty", exp_q.size(), 0);
        tick(3);
        chk("frame_done_total", done_cnt, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
